// File: rtl/a2s_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR + R) between NREQ read masters.
// Optional DATA-phase watchdog with DRAIN recovery is enabled by defining A2S_ARB_TIMEOUT_EN.
module a2s_rd_arbiter #(
  parameter int NREQ      = 2,
  parameter int TO_CYCLES = 1024
) (
  input  logic                AXI_clk,
  input  logic                rst_n,
  input  logic [NREQ*32-1:0]  req_araddr,
  input  logic [NREQ-1:0]     req_arvalid,
  output logic [NREQ-1:0]     req_arready,
  output logic [NREQ-1:0]     req_rvalid,
  input  logic [NREQ-1:0]     req_rready,
  output logic [NREQ-1:0]     req_rlast,
  output logic [31:0]         AXI_araddr,
  output logic                AXI_arvalid,
  input  logic                AXI_arready,
  input  logic                AXI_rvalid,
  output logic                AXI_rready,
  input  logic                AXI_rlast,
  output logic [NREQ-1:0]     grant,
  output logic                busy,
  output logic [7:0]          beat_cnt,
  input  logic                err_clr,
  output logic                arb_err
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [GW:0] NREQ_W = (GW+1)'(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [GW-1:0]   gidx_q, gidx_d;
  logic [GW-1:0]   last_q, last_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic            arb_err_q, arb_err_d;

  logic            in_addr, in_data, in_drain;
  logic            sel_arvalid, sel_rready;
  logic [31:0]     sel_araddr;
  logic            r_hs;

  // Round-robin search: rotate the request vector so bit 0 is master last+1.
  logic [GW:0]       rr_start, rr_pos, rr_sum;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [GW-1:0]     pick_idx;

  always_comb begin
    rr_start = {1'b0, last_q} + (GW+1)'(1);
    if (rr_start == NREQ_W) begin
      rr_start = '0;
    end
    req_dbl = {req_arvalid, req_arvalid};
    req_rot = req_dbl[rr_start +: NREQ];
    rr_pos  = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        rr_pos = (GW+1)'(j);
      end
    end
    rr_sum = rr_start + rr_pos;
    if (rr_sum >= NREQ_W) begin
      rr_sum = rr_sum - NREQ_W;
    end
    pick_idx = rr_sum[GW-1:0];
  end

  assign in_addr  = (state_q == S_ADDR);
  assign in_data  = (state_q == S_DATA);
  assign in_drain = (state_q == S_DRAIN);

  always_comb begin
    sel_araddr = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_araddr = sel_araddr | (req_araddr[32*i +: 32] & {32{grant_q[i]}});
    end
  end

  assign sel_arvalid = |(req_arvalid & grant_q);
  assign sel_rready  = |(req_rready & grant_q);

  assign AXI_araddr  = in_addr ? sel_araddr : 32'h0;
  assign AXI_arvalid = in_addr & sel_arvalid;
  assign AXI_rready  = (in_data & sel_rready) | in_drain;
  assign r_hs        = AXI_rvalid & AXI_rready;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign req_arready[gi] = in_addr & grant_q[gi] & AXI_arready;
    assign req_rvalid[gi]  = in_data & grant_q[gi] & AXI_rvalid;
    assign req_rlast[gi]   = in_data & grant_q[gi] & AXI_rlast;
  end

  assign grant    = grant_q;
  assign busy     = (state_q != S_IDLE);
  assign beat_cnt = beat_cnt_q;
  assign arb_err  = arb_err_q;

`ifdef A2S_ARB_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        err_set;
`else
  logic [15:0] unused_to;
  assign unused_to = 16'(TO_CYCLES);
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
`ifdef A2S_ARB_TIMEOUT_EN
    wdog_d     = wdog_q;
    err_set    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_arvalid) begin
          state_d = S_ADDR;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          gidx_d  = pick_idx;
        end
      end
      S_ADDR: begin
        // A master withdrawing its request gives up the slot without counting as served.
        if (!sel_arvalid) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else if (AXI_arready) begin
          state_d    = S_DATA;
          beat_cnt_d = 8'd0;
`ifdef A2S_ARB_TIMEOUT_EN
          wdog_d     = 16'd0;
`endif
        end
      end
      S_DATA: begin
        if (r_hs && AXI_rlast) begin
          state_d = S_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
`ifdef A2S_ARB_TIMEOUT_EN
        else if (wdog_q == 16'(TO_CYCLES - 1)) begin
          state_d = S_DRAIN;
          err_set = 1'b1;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
`ifdef A2S_ARB_TIMEOUT_EN
      S_DRAIN: begin
        if (r_hs && AXI_rlast) begin
          state_d = S_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    if (r_hs && (beat_cnt_q != 8'hFF)) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end
  end

`ifdef A2S_ARB_TIMEOUT_EN
  // A new timeout takes priority over a clear arriving in the same cycle.
  assign arb_err_d = err_set | (arb_err_q & ~err_clr);
`else
  logic unused_clr;
  assign unused_clr = err_clr;
  assign arb_err_d  = 1'b0;
`endif

  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_q     <= GW'(NREQ - 1);
      beat_cnt_q <= 8'd0;
      arb_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      arb_err_q  <= arb_err_d;
    end
  end

`ifdef A2S_ARB_TIMEOUT_EN
  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= 16'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

endmodule

// File: tb/tb_a2s_rd_arbiter.sv
// Directed bench for a2s_rd_arbiter with a transaction-level reference model checked every cycle.
// Build with A2S_ARB_TIMEOUT_EN defined to exercise the watchdog / DRAIN path.
module tb_a2s_rd_arbiter;

  localparam int NREQ   = 2;
  localparam int TO_CYC = 32;
`ifdef A2S_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                AXI_clk;
  logic                rst_n;
  logic [NREQ*32-1:0]  req_araddr;
  logic [NREQ-1:0]     req_arvalid;
  logic [NREQ-1:0]     req_arready;
  logic [NREQ-1:0]     req_rvalid;
  logic [NREQ-1:0]     req_rready;
  logic [NREQ-1:0]     req_rlast;
  logic [31:0]         AXI_araddr;
  logic                AXI_arvalid;
  logic                AXI_arready;
  logic                AXI_rvalid;
  logic                AXI_rready;
  logic                AXI_rlast;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic [7:0]          beat_cnt;
  logic                err_clr;
  logic                arb_err;

  int n_checks = 0;
  int n_fail   = 0;

  a2s_rd_arbiter #(.NREQ(NREQ), .TO_CYCLES(TO_CYC)) dut (
    .AXI_clk     (AXI_clk),
    .rst_n       (rst_n),
    .req_araddr  (req_araddr),
    .req_arvalid (req_arvalid),
    .req_arready (req_arready),
    .req_rvalid  (req_rvalid),
    .req_rready  (req_rready),
    .req_rlast   (req_rlast),
    .AXI_araddr  (AXI_araddr),
    .AXI_arvalid (AXI_arvalid),
    .AXI_arready (AXI_arready),
    .AXI_rvalid  (AXI_rvalid),
    .AXI_rready  (AXI_rready),
    .AXI_rlast   (AXI_rlast),
    .grant       (grant),
    .busy        (busy),
    .beat_cnt    (beat_cnt),
    .err_clr     (err_clr),
    .arb_err     (arb_err)
  );

  initial begin
    AXI_clk = 1'b0;
    forever #5 AXI_clk = ~AXI_clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got running required finished");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which master owns the channel and in which phase of its burst.
  typedef enum int {P_IDLE, P_ADDR, P_DATA, P_DRAIN} phase_t;
  phase_t m_ph    = P_IDLE;
  int     m_g     = 0;
  int     m_last  = NREQ - 1;
  int     m_beats = 0;
  int     m_wd    = 0;
  bit     m_err   = 1'b0;

  initial forever begin
    @(posedge AXI_clk or negedge rst_n);
    begin
      bit found;
      bit hs;
      bit set_err;
      int idx;
      found   = 1'b0;
      set_err = 1'b0;
      if (!rst_n) begin
        m_ph = P_IDLE; m_g = 0; m_last = NREQ - 1; m_beats = 0; m_wd = 0; m_err = 1'b0;
      end else begin
        case (m_ph)
          P_IDLE: begin
            for (int k = 1; k <= NREQ; k++) begin
              idx = (m_last + k) % NREQ;
              if (!found && req_arvalid[idx]) begin
                found = 1'b1;
                m_g   = idx;
              end
            end
            if (found) m_ph = P_ADDR;
          end
          P_ADDR: begin
            if (!req_arvalid[m_g]) m_ph = P_IDLE;
            else if (AXI_arready) begin
              m_ph = P_DATA; m_beats = 0; m_wd = 0;
            end
          end
          P_DATA: begin
            hs = AXI_rvalid && req_rready[m_g];
            if (hs) m_beats = (m_beats < 255) ? m_beats + 1 : 255;
            if (hs && AXI_rlast) begin
              m_ph = P_IDLE; m_last = m_g;
            end else if (TO_EN) begin
              m_wd = m_wd + 1;
              if (m_wd >= TO_CYC) begin
                m_ph = P_DRAIN; set_err = 1'b1;
              end
            end
          end
          P_DRAIN: begin
            if (AXI_rvalid) m_beats = (m_beats < 255) ? m_beats + 1 : 255;
            if (AXI_rvalid && AXI_rlast) begin
              m_ph = P_IDLE; m_last = m_g;
            end
          end
          default: m_ph = P_IDLE;
        endcase
        if (set_err) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  initial forever begin
    @(negedge AXI_clk);
    begin
      logic [NREQ-1:0] mask, e_arready, e_rvalid, e_rlast;
      logic [31:0]     e_araddr;
      logic            e_arvalid, e_rready;
      mask      = (m_ph == P_IDLE) ? '0 : NREQ'(1) << m_g;
      e_arready = '0; e_rvalid = '0; e_rlast = '0;
      e_araddr  = 32'h0; e_arvalid = 1'b0; e_rready = 1'b0;
      case (m_ph)
        P_ADDR: begin
          e_araddr  = req_araddr[32*m_g +: 32];
          e_arvalid = req_arvalid[m_g];
          e_arready = AXI_arready ? mask : '0;
        end
        P_DATA: begin
          e_rready = req_rready[m_g];
          e_rvalid = AXI_rvalid ? mask : '0;
          e_rlast  = AXI_rlast ? mask : '0;
        end
        P_DRAIN: e_rready = 1'b1;
        default: ;
      endcase
      chk("m_grant",    32'(grant),       32'(mask));
      chk("m_busy",     32'(busy),        32'(m_ph != P_IDLE));
      chk("m_araddr",   AXI_araddr,       e_araddr);
      chk("m_arvalid",  32'(AXI_arvalid), 32'(e_arvalid));
      chk("m_arready",  32'(req_arready), 32'(e_arready));
      chk("m_rready",   32'(AXI_rready),  32'(e_rready));
      chk("m_rvalid",   32'(req_rvalid),  32'(e_rvalid));
      chk("m_rlast",    32'(req_rlast),   32'(e_rlast));
      chk("m_beat_cnt", 32'(beat_cnt),    32'(m_beats));
      chk("m_arb_err",  32'(arb_err),     32'(m_err));
    end
  end

  task automatic tick();
    @(posedge AXI_clk);
    #1;
  endtask

  // One burst for master g: address handshake, nbeats beats, optional 3-cycle rready stall.
  task automatic run_burst(input int g, input int nbeats, input int stall_at);
    int k;
    logic [7:0] saved;
    logic [NREQ-1:0] gm;
    gm = NREQ'(1) << g;
    k = 0;
    while (!AXI_arvalid && k < 8) begin
      tick();
      k++;
    end
    chk("arvalid_wait", 32'(AXI_arvalid), 32'd1);
    chk("burst_grant", 32'(grant), 32'(gm));
    chk("burst_araddr", AXI_araddr, req_araddr[32*g +: 32]);
    AXI_arready = 1'b1;
    tick();
    AXI_arready = 1'b0;
    chk("beat_start", 32'(beat_cnt), 32'd0);
    for (int i = 0; i < nbeats; i++) begin
      if (i == stall_at) begin
        saved = beat_cnt;
        req_rready[g] = 1'b0;
        AXI_rvalid = 1'b1;
        AXI_rlast  = 1'b1;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk("stall_rready", 32'(AXI_rready), 32'd0);
          tick();
          chk("stall_beat", 32'(beat_cnt), 32'(saved));
        end
        req_rready[g] = 1'b1;
      end
      AXI_rvalid = 1'b1;
      AXI_rlast  = (i == nbeats - 1);
      #1;
      chk("nongrant_rvalid", 32'(req_rvalid & ~gm), 32'd0);
      tick();
    end
    AXI_rvalid = 1'b0;
    AXI_rlast  = 1'b0;
    chk("burst_beats", 32'(beat_cnt), 32'(nbeats));
    chk("burst_end_grant", 32'(grant), 32'd0);
    $display("burst master=%0d beats=%0d beat_cnt=%0d", g, nbeats, beat_cnt);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_araddr  = {32'h2000_0100, 32'h3000_0000};
    req_arvalid = '1;
    req_rready  = '1;
    AXI_arready = 1'b0;
    AXI_rvalid  = 1'b0;
    AXI_rlast   = 1'b0;
    err_clr     = 1'b0;

    // Test 1: reset with all masters requesting.
    repeat (3) @(negedge AXI_clk);
    chk("rst_outputs", {grant, busy, AXI_arvalid, AXI_rready, req_arready, req_rvalid, req_rlast, beat_cnt, arb_err},
        32'd0);
    chk("rst_araddr", AXI_araddr, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_first_grant", 32'(grant), 32'h1);
    $display("reset released grant=%b", grant);

    // Test 2: both masters held, 16-beat bursts alternate.
    run_burst(0, 16, -1);
    run_burst(1, 16, -1);
    run_burst(0, 16, -1);
    run_burst(1, 16, -1);

    // Test 3: master1 alone with a specific address.
    req_arvalid = 2'b10;
    req_araddr[63:32] = 32'h1000_0040;
    tick();
    chk("m1_araddr", AXI_araddr, 32'h1000_0040);
    chk("m1_arvalid", 32'(AXI_arvalid), 32'd1);
    run_burst(1, 4, -1);

    // Test 4: same master back-to-back with a 3-cycle rready stall mid-burst.
    run_burst(1, 8, 3);

    // Test 6: master0 withdraws in ADDR; last pointer must stay put.
    req_arvalid = 2'b11;
    tick();
    chk("drop_grant", 32'(grant), 32'h1);
    req_arvalid = 2'b10;
    #1;
    chk("drop_arvalid", 32'(AXI_arvalid), 32'd0);
    tick();
    chk("drop_idle_grant", 32'(grant), 32'd0);
    chk("drop_idle_busy", 32'(busy), 32'd0);
    req_arvalid = 2'b11;
    run_burst(0, 2, -1);
    run_burst(1, 2, -1);
    req_arvalid = 2'b00;
    tick();

    // Test 5: slave stalls the R channel.
    req_arvalid = 2'b01;
    tick();
    chk("to_grant", 32'(grant), 32'h1);
    AXI_arready = 1'b1;
    tick();
    AXI_arready = 1'b0;
    req_arvalid = 2'b00;
    req_rready  = 2'b00;
`ifdef A2S_ARB_TIMEOUT_EN
    repeat (TO_CYC - 1) tick();
    chk("to_before", 32'(arb_err), 32'd0);
    tick();
    chk("to_err_set", 32'(arb_err), 32'd1);
    chk("to_drain_rready", 32'(AXI_rready), 32'd1);
    AXI_rvalid = 1'b1;
    #1;
    chk("to_drain_rvalid", 32'(req_rvalid), 32'd0);
    tick();
    AXI_rlast = 1'b1;
    tick();
    AXI_rvalid = 1'b0;
    AXI_rlast  = 1'b0;
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_err_sticky", 32'(arb_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(arb_err), 32'd0);
    $display("timeout drained arb_err=%0d", arb_err);
`else
    repeat (TO_CYC + 8) tick();
    chk("nto_busy", 32'(busy), 32'd1);
    chk("nto_err", 32'(arb_err), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    req_rready = 2'b11;
    AXI_rvalid = 1'b1;
    AXI_rlast  = 1'b1;
    tick();
    AXI_rvalid = 1'b0;
    AXI_rlast  = 1'b0;
    chk("nto_done", 32'(busy), 32'd0);
    chk("nto_beats", 32'(beat_cnt), 32'd1);
    $display("stall without watchdog completed beat_cnt=%0d", beat_cnt);
`endif
    req_rready = 2'b11;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
